// File: rtl/meduram_pkg.sv
// Shared widths and types for the banked memory write path.
package meduram_pkg;

    // Index width for n items; a single item still needs one bit of index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned ADDR_W_DEF     = 8;
    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned BANK_IDX_W_DEF = idx_width(4);
    localparam int unsigned AGENT_IDX_W_DEF = idx_width(2);

    // Per-bank write bundle for the default geometry.
    typedef struct packed {
        logic                  wren;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } bank_wr_t;

endpackage

// File: rtl/write_collision_arbiter_if.sv
// Agent-side write request bus: agents are the master, the arbiter the slave.
interface write_collision_arbiter_if
    import meduram_pkg::*;
#(
    parameter int unsigned NB_WRAGENT = 2,
    parameter int unsigned NB_BANK    = 4,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BW = idx_width(NB_BANK);

    logic [NB_WRAGENT-1:0]            wrvalid;
    logic [NB_WRAGENT-1:0]            wrready;
    logic [NB_WRAGENT*BW-1:0]         wrbank;
    logic [NB_WRAGENT*ADDR_WIDTH-1:0] wraddr;
    logic [NB_WRAGENT*DATA_WIDTH-1:0] wrdata;

    modport master (output wrvalid, output wrbank, output wraddr, output wrdata, input wrready);
    modport slave  (input wrvalid, input wrbank, input wraddr, input wrdata, output wrready);

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index, wrapping.
module rr_arbiter
    import meduram_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          aclk,
    input  logic          srst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] r_ptr;
    logic          w_found;
    int            w_pos;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_pos   = 0;
        for (int k = 1; k <= int'(N); k++) begin
            w_pos = int'(r_ptr) + k;
            if (w_pos >= int'(N)) begin
                w_pos = w_pos - int'(N);
            end
            for (int i = 0; i < int'(N); i++) begin
                if (!w_found && req[i] && (w_pos == i)) begin
                    gnt[i]  = 1'b1;
                    gnt_idx = IW'(i);
                    w_found = 1'b1;
                end
            end
        end
    end

    // Reset to the last index so agent 0 is first after reset.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_ptr <= IW'(N - 1);
        end else if (|req) begin
            r_ptr <= gnt_idx;
        end
    end

endmodule

// File: rtl/write_collision_arbiter.sv
// Per-bank round-robin write arbitration with registered bank ports,
// a collision flag and a saturating collision counter.
module write_collision_arbiter
    import meduram_pkg::*;
#(
    parameter int unsigned NB_WRAGENT  = 2,
    parameter int unsigned NB_BANK     = 4,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                          aclk,
    input  logic                          srst,
    write_collision_arbiter_if.slave      wr_if,
    output logic [NB_BANK-1:0]            bank_wren,
    output logic [NB_BANK*ADDR_WIDTH-1:0] bank_addr,
    output logic [NB_BANK*DATA_WIDTH-1:0] bank_data,
    output logic                          collision,
    input  logic                          collision_clr,
    output logic [COUNT_WIDTH-1:0]        collision_cnt
);

    localparam int unsigned BW = idx_width(NB_BANK);
    localparam int unsigned AW = idx_width(NB_WRAGENT);

    typedef struct packed {
        logic                  wren;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } bank_wr_p_t;

    logic [BW-1:0]         w_bank_a [NB_WRAGENT];
    logic [ADDR_WIDTH-1:0] w_addr_a [NB_WRAGENT];
    logic [DATA_WIDTH-1:0] w_data_a [NB_WRAGENT];
    logic [NB_WRAGENT-1:0] w_req    [NB_BANK];
    logic [NB_WRAGENT-1:0] w_gnt    [NB_BANK];
    logic [AW-1:0]         w_gnt_idx[NB_BANK];
    logic [NB_WRAGENT-1:0] w_ready;
    logic                  w_coll;
    int                    w_pop;

    logic                   r_coll;
    logic [COUNT_WIDTH-1:0] r_cnt;

    genvar gi, gb;
    generate
        for (gi = 0; gi < NB_WRAGENT; gi++) begin : g_agent
            assign w_bank_a[gi] = wr_if.wrbank[gi*BW +: BW];
            assign w_addr_a[gi] = wr_if.wraddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_data_a[gi] = wr_if.wrdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end

        for (gb = 0; gb < NB_BANK; gb++) begin : g_bank
            logic [ADDR_WIDTH-1:0] w_sel_addr;
            logic [DATA_WIDTH-1:0] w_sel_data;
            bank_wr_p_t            r_bank;

            for (gi = 0; gi < NB_WRAGENT; gi++) begin : g_req
                assign w_req[gb][gi] = wr_if.wrvalid[gi] & (w_bank_a[gi] == BW'(gb));
            end

            rr_arbiter #(.N(NB_WRAGENT)) u_arb (
                .aclk    (aclk),
                .srst    (srst),
                .req     (w_req[gb]),
                .gnt     (w_gnt[gb]),
                .gnt_idx (w_gnt_idx[gb])
            );

            always_comb begin
                w_sel_addr = '0;
                w_sel_data = '0;
                for (int i = 0; i < int'(NB_WRAGENT); i++) begin
                    if (int'(w_gnt_idx[gb]) == i) begin
                        w_sel_addr = w_addr_a[i];
                        w_sel_data = w_data_a[i];
                    end
                end
            end

            // Address/data only move on a write so the port holds its last value.
            always_ff @(posedge aclk) begin
                if (srst) begin
                    r_bank <= '0;
                end else begin
                    r_bank.wren <= |w_gnt[gb];
                    if (|w_gnt[gb]) begin
                        r_bank.addr <= w_sel_addr;
                        r_bank.data <= w_sel_data;
                    end
                end
            end

            assign bank_wren[gb]                         = r_bank.wren;
            assign bank_addr[gb*ADDR_WIDTH +: ADDR_WIDTH] = r_bank.addr;
            assign bank_data[gb*DATA_WIDTH +: DATA_WIDTH] = r_bank.data;
        end
    endgenerate

    always_comb begin
        w_ready = '0;
        for (int b = 0; b < int'(NB_BANK); b++) begin
            w_ready = w_ready | w_gnt[b];
        end
    end

    assign wr_if.wrready = srst ? '0 : w_ready;

    always_comb begin
        w_coll = 1'b0;
        w_pop  = 0;
        for (int b = 0; b < int'(NB_BANK); b++) begin
            w_pop = 0;
            for (int i = 0; i < int'(NB_WRAGENT); i++) begin
                w_pop = w_pop + int'(w_req[b][i]);
            end
            if (w_pop >= 2) begin
                w_coll = 1'b1;
            end
        end
    end

    // Clear beats a simultaneous collision; the count sticks at all-ones.
    always_ff @(posedge aclk) begin
        if (srst) begin
            r_coll <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_coll <= w_coll;
            if (collision_clr) begin
                r_cnt <= '0;
            end else if (w_coll && (r_cnt != '1)) begin
                r_cnt <= r_cnt + COUNT_WIDTH'(1);
            end
        end
    end

    assign collision     = r_coll;
    assign collision_cnt = r_cnt;

endmodule
